cv32e41s_sleep_cg_ctrl: RTL and testbench
=========================================

// Module: cv32e41s_sleep_cg_ctrl
// PURPOSE
//  Sequences the core clock gate: drains the pipeline on a sleep request, drops the gate
//  enable once idle for a programmable hysteresis, and restores the clock on a masked wake
//  event. Runs on the free-running clock; gate_en_o drives en_i of cv32e41s_clock_gate.
//  scan_cg_en_i of the gate is wired at top level, not here.
// PARAMETERS
//  NUM_WAKE    4  number of wake sources
//  IDLE_CNT_W  4  width of idle hysteresis counter / idle_thresh_i
//  WAKE_DELAY  2  cycles in WAKE before RUN (legal range 1..15)
// PORTS
//  clk_i          in   1           free-running clock (never gated)
//  rst_ni         in   1           async reset, active-low
//  sleep_req_i    in   1           level request to sleep (e.g. WFI retired)
//  idle_i         in   1           pipeline/LSU idle indication
//  idle_thresh_i  in   IDLE_CNT_W  idle cycles required before gating; quasi-static
//  wake_i         in   NUM_WAKE    wake events (irq, debug, ...), level
//  wake_mask_i    in   NUM_WAKE    1 = source enabled
//  gate_en_o      out  1           clock gate enable, registered
//  core_sleep_o   out  1           core asleep/waking, registered
//  wake_src_o     out  NUM_WAKE    masked wake vector captured on wake, registered
// BEHAVIOUR
//  - wake_any = |(wake_i & wake_mask_i). All outputs are flops; values follow the state.
//  - Reset: state RUN, gate_en_o=1, core_sleep_o=0, wake_src_o=0, counters 0.
//    Async assert; deassert is sync to clk_i (done upstream).
//  - RUN: gate_en=1, core_sleep=0. Entered with sleep_req_i=1 and wake_any=0 -> DRAIN,
//    idle_cnt=0. If wake_any=1, stay in RUN (wake wins).
//  - DRAIN: gate_en=1, core_sleep=0. Priority order:
//    (1) wake_any=1 or sleep_req_i=0 -> RUN (abort).
//    (2) idle_i=0 -> idle_cnt=0.
//    (3) idle_i=1 and idle_cnt==idle_thresh_i -> SLEEP.
//    (4) else idle_cnt++, saturating at 2^IDLE_CNT_W-1.
//    thresh=0 -> first idle cycle in DRAIN goes to SLEEP. thresh=T -> T+1 consecutive
//    idle cycles are needed.
//  - SLEEP: gate_en=0, core_sleep=1. wake_any=1 -> WAKE; wake_src_o <= wake_i&wake_mask_i.
//    sleep_req_i and idle_i are ignored in SLEEP.
//  - WAKE: gate_en=1, core_sleep=1. wake_cnt counts WAKE_DELAY cycles, then -> RUN.
//    wake_cnt reloads on entry. wake_i is ignored here.
//  - wake_src_o holds until the next SLEEP->WAKE capture.
//  - After RUN re-entry with sleep_req_i still 1, DRAIN is re-entered next cycle (level
//    semantics); the core must drop the request on wake.
//  - Latency: gate_en_o falls the cycle after the qualifying idle sample and rises the
//    cycle after the wake sample. Wake-to-RUN is WAKE_DELAY+1 edges.
//  - Glitch-free: gate_en_o is a flop on clk_i; the gate latch handles low-phase timing.
//  - Illegal/unused state encodings -> RUN.
//  - idle_thresh_i change mid-DRAIN takes effect on the next compare.
// TESTING
//  1. Reset with rst_ni=0 mid-SLEEP -> gate_en_o=1 and core_sleep_o=0 immediately
//     (async), state RUN.
//  2. thresh=3, req=1, idle=1 steady -> gate_en_o=0 five edges after req
//     (1 to DRAIN + 4 idle cycles).
//  3. thresh=3, idle pattern 1,1,0,1,1,1,1 -> idle_cnt restarts after the 0;
//     SLEEP only after the last four 1s.
//  4. In SLEEP, wake_i=4'b0110, mask=4'b0100 -> WAKE next edge, wake_src_o=4'b0100,
//     gate_en_o=1; RUN after WAKE_DELAY=2 more edges.
//  5. DRAIN with wake_i[0]=1 (masked in) at the same edge idle_cnt hits thresh
//     -> returns to RUN, gate_en_o stays 1.
//  6. Masked-out wake in SLEEP (mask=0) -> stays in SLEEP; sleep_req_i toggling in SLEEP
//     -> no effect.

Source files
------------

// File: rtl/cv32e41s_sleep_cg_ctrl.sv
// cv32e41s_sleep_cg_ctrl
//   Sequences the core clock gate. A sleep request first drains the pipeline; once the
//   pipeline has been idle for a programmable hysteresis, the gate enable drops. A masked
//   wake event restores the clock, then holds core_sleep_o for a short settling window
//   before the core is considered running again. Runs on the free-running clock.
//
// Ports
//   clk_i          free-running clock (never gated)
//   rst_ni         asynchronous reset, active-low
//   sleep_req_i    level request to sleep (e.g. WFI retired)
//   idle_i         pipeline/LSU idle indication
//   idle_thresh_i  idle cycles required before gating (quasi-static)
//   wake_i         wake events, level
//   wake_mask_i    per-source wake enable (1 = enabled)
//   gate_en_o      clock gate enable, registered
//   core_sleep_o   core asleep or waking, registered
//   wake_src_o     masked wake vector captured on wake, registered

module cv32e41s_sleep_cg_ctrl #(
   parameter int unsigned NUM_WAKE   = 4,
   parameter int unsigned IDLE_CNT_W = 4,
   parameter int unsigned WAKE_DELAY = 2
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  sleep_req_i,
   input  logic                  idle_i,
   input  logic [IDLE_CNT_W-1:0] idle_thresh_i,
   input  logic [NUM_WAKE-1:0]   wake_i,
   input  logic [NUM_WAKE-1:0]   wake_mask_i,
   output logic                  gate_en_o,
   output logic                  core_sleep_o,
   output logic [NUM_WAKE-1:0]   wake_src_o
);

   localparam logic [1:0] RUN   = 2'b00;
   localparam logic [1:0] DRAIN = 2'b01;
   localparam logic [1:0] SLEEP = 2'b10;
   localparam logic [1:0] WAKE  = 2'b11;

   localparam int unsigned WAKE_CNT_W = 4;
   // Counter counts down to zero, so WAKE_DELAY cycles need a load of WAKE_DELAY-1.
   localparam logic [WAKE_CNT_W-1:0] WAKE_CNT_LOAD = WAKE_CNT_W'(WAKE_DELAY - 1);

   logic [1:0]            state_q, state_d;
   logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [WAKE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
   logic [NUM_WAKE-1:0]   wake_src_q, wake_src_d;
   logic                  gate_en_q, gate_en_d;
   logic                  core_sleep_q, core_sleep_d;

   logic [NUM_WAKE-1:0]   wake_masked;
   logic                  wake_any;

   assign wake_masked = wake_i & wake_mask_i;
   assign wake_any    = |wake_masked;

   always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      wake_cnt_d = wake_cnt_q;
      wake_src_d = wake_src_q;

      case (state_q)
         RUN: begin
            // A pending wake blocks sleep entry.
            if (sleep_req_i && !wake_any) begin
               state_d    = DRAIN;
               idle_cnt_d = '0;
            end
         end
         DRAIN: begin
            if (wake_any || !sleep_req_i) begin
               state_d = RUN;
            end else if (!idle_i) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q == idle_thresh_i) begin
               state_d = SLEEP;
            end else if (idle_cnt_q != {IDLE_CNT_W{1'b1}}) begin
               idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
            end
         end
         SLEEP: begin
            if (wake_any) begin
               state_d    = WAKE;
               wake_cnt_d = WAKE_CNT_LOAD;
               wake_src_d = wake_masked;
            end
         end
         WAKE: begin
            if (wake_cnt_q == '0) begin
               state_d = RUN;
            end else begin
               wake_cnt_d = wake_cnt_q - WAKE_CNT_W'(1);
            end
         end
         default: state_d = RUN;
      endcase

      // Outputs are registered from the next state so they line up with it.
      gate_en_d    = (state_d != SLEEP);
      core_sleep_d = (state_d == SLEEP) || (state_d == WAKE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= RUN;
         idle_cnt_q   <= '0;
         wake_cnt_q   <= '0;
         wake_src_q   <= '0;
         gate_en_q    <= 1'b1;
         core_sleep_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idle_cnt_q   <= idle_cnt_d;
         wake_cnt_q   <= wake_cnt_d;
         wake_src_q   <= wake_src_d;
         gate_en_q    <= gate_en_d;
         core_sleep_q <= core_sleep_d;
      end
   end

   assign gate_en_o    = gate_en_q;
   assign core_sleep_o = core_sleep_q;
   assign wake_src_o   = wake_src_q;

endmodule

// File: tb/tb_cv32e41s_sleep_cg_ctrl.sv
// Directed testbench for cv32e41s_sleep_cg_ctrl: a vector table applied one clock per
// entry, followed by hand-written asynchronous reset checks.

module tb_cv32e41s_sleep_cg_ctrl;

   logic       clk;
   logic       rst_n;
   logic       sleep_req;
   logic       idle;
   logic [3:0] idle_thresh;
   logic [3:0] wake;
   logic [3:0] wake_mask;
   logic       gate_en;
   logic       core_sleep;
   logic [3:0] wake_src;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic       req;
      logic       idl;
      logic [3:0] thr;
      logic [3:0] wk;
      logic [3:0] msk;
      logic       exp_gate;
      logic       exp_sleep;
      logic [3:0] exp_src;
      string      name;
   } vec_t;

   vec_t vecs[$];

   cv32e41s_sleep_cg_ctrl #(
      .NUM_WAKE   (4),
      .IDLE_CNT_W (4),
      .WAKE_DELAY (2)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .sleep_req_i   (sleep_req),
      .idle_i        (idle),
      .idle_thresh_i (idle_thresh),
      .wake_i        (wake),
      .wake_mask_i   (wake_mask),
      .gate_en_o     (gate_en),
      .core_sleep_o  (core_sleep),
      .wake_src_o    (wake_src)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic req, input logic idl, input logic [3:0] thr,
                      input logic [3:0] wk, input logic [3:0] msk, input logic eg,
                      input logic es, input logic [3:0] esrc, input string nm);
      vec_t v;
      v.req = req; v.idl = idl; v.thr = thr; v.wk = wk; v.msk = msk;
      v.exp_gate = eg; v.exp_sleep = es; v.exp_src = esrc; v.name = nm;
      vecs.push_back(v);
   endtask

   task automatic check(input string nm, input logic eg, input logic es,
                        input logic [3:0] esrc);
      n_cmp++;
      if (gate_en !== eg || core_sleep !== es || wake_src !== esrc) begin
         n_bad++;
         $display("FAIL %s: got gate=%b sleep=%b src=%b, want gate=%b sleep=%b src=%b",
                  nm, gate_en, core_sleep, wake_src, eg, es, esrc);
      end
   endtask

   initial begin
      // req idl thr wk msk | gate sleep src
      // thresh=3 steady idle: gate drops 5 edges after request
      add(1, 1, 3, 4'h0, 4'h0, 1, 0, 4'h0, "t2_enter_drain");
      add(1, 1, 3, 4'h0, 4'h0, 1, 0, 4'h0, "t2_idle1");
      add(1, 1, 3, 4'h0, 4'h0, 1, 0, 4'h0, "t2_idle2");
      add(1, 1, 3, 4'h0, 4'h0, 1, 0, 4'h0, "t2_idle3");
      add(1, 1, 3, 4'h0, 4'h0, 0, 1, 4'h0, "t2_sleep");
      // masked-out wake and request toggling have no effect in SLEEP
      add(0, 0, 3, 4'hf, 4'h0, 0, 1, 4'h0, "t6_masked_wake");
      add(1, 1, 3, 4'hf, 4'h0, 0, 1, 4'h0, "t6_req_toggle");
      // wake 0110 masked by 0100
      add(0, 0, 3, 4'h6, 4'h4, 1, 1, 4'h4, "t4_wake_entry");
      add(0, 0, 3, 4'h0, 4'h4, 1, 1, 4'h4, "t4_wake_hold");
      add(0, 0, 3, 4'h0, 4'h4, 1, 0, 4'h4, "t4_run");
      // idle pattern 1,1,0,1,1,1,1 in DRAIN
      add(1, 1, 3, 4'h0, 4'h0, 1, 0, 4'h4, "t3_enter_drain");
      add(1, 1, 3, 4'h0, 4'h0, 1, 0, 4'h4, "t3_i1");
      add(1, 1, 3, 4'h0, 4'h0, 1, 0, 4'h4, "t3_i2");
      add(1, 0, 3, 4'h0, 4'h0, 1, 0, 4'h4, "t3_i0_restart");
      add(1, 1, 3, 4'h0, 4'h0, 1, 0, 4'h4, "t3_i4");
      add(1, 1, 3, 4'h0, 4'h0, 1, 0, 4'h4, "t3_i5");
      add(1, 1, 3, 4'h0, 4'h0, 1, 0, 4'h4, "t3_i6");
      add(1, 1, 3, 4'h0, 4'h0, 0, 1, 4'h4, "t3_sleep");
      // wake on src 0, wake_i held during WAKE is ignored
      add(0, 0, 3, 4'h1, 4'h1, 1, 1, 4'h1, "wake0_entry");
      add(0, 0, 3, 4'h1, 4'h1, 1, 1, 4'h1, "wake0_hold");
      add(0, 0, 3, 4'h1, 4'h1, 1, 0, 4'h1, "wake0_run");
      // wake arrives the same cycle idle_cnt hits thresh
      add(1, 1, 3, 4'h0, 4'h1, 1, 0, 4'h1, "t5_enter_drain");
      add(1, 1, 3, 4'h0, 4'h1, 1, 0, 4'h1, "t5_c1");
      add(1, 1, 3, 4'h0, 4'h1, 1, 0, 4'h1, "t5_c2");
      add(1, 1, 3, 4'h0, 4'h1, 1, 0, 4'h1, "t5_c3");
      add(1, 1, 3, 4'h1, 4'h1, 1, 0, 4'h1, "t5_wake_abort");
      add(1, 1, 3, 4'h1, 4'h1, 1, 0, 4'h1, "t5_wake_blocks");
      // thresh=0: first idle cycle in DRAIN sleeps
      add(1, 1, 0, 4'h0, 4'h1, 1, 0, 4'h1, "th0_enter_drain");
      add(1, 1, 0, 4'h0, 4'h1, 0, 1, 4'h1, "th0_sleep");
      add(0, 0, 0, 4'h8, 4'h8, 1, 1, 4'h8, "wake3_entry");
      add(0, 0, 0, 4'h0, 4'h8, 1, 1, 4'h8, "wake3_hold");
      add(0, 0, 0, 4'h0, 4'h8, 1, 0, 4'h8, "wake3_run");
      // dropping the request aborts DRAIN
      add(1, 0, 2, 4'h0, 4'h0, 1, 0, 4'h8, "abort_enter_drain");
      add(0, 1, 2, 4'h0, 4'h0, 1, 0, 4'h8, "abort_req_drop");
      // thresh=2 -> three idle cycles, ends asleep for the reset test
      add(1, 1, 2, 4'h0, 4'h0, 1, 0, 4'h8, "th2_enter_drain");
      add(1, 1, 2, 4'h0, 4'h0, 1, 0, 4'h8, "th2_c1");
      add(1, 1, 2, 4'h0, 4'h0, 1, 0, 4'h8, "th2_c2");
      add(1, 1, 2, 4'h0, 4'h0, 0, 1, 4'h8, "th2_sleep");

      rst_n       = 1'b0;
      sleep_req   = 1'b0;
      idle        = 1'b0;
      idle_thresh = 4'd3;
      wake        = 4'h0;
      wake_mask   = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 1'b1, 1'b0, 4'h0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         sleep_req   = vecs[i].req;
         idle        = vecs[i].idl;
         idle_thresh = vecs[i].thr;
         wake        = vecs[i].wk;
         wake_mask   = vecs[i].msk;
         @(posedge clk);
         #1;
         check(vecs[i].name, vecs[i].exp_gate, vecs[i].exp_sleep, vecs[i].exp_src);
      end

      // Asynchronous reset mid-SLEEP, away from any clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_immediate", 1'b1, 1'b0, 4'h0);
      @(posedge clk);
      #1;
      check("reset_held", 1'b1, 1'b0, 4'h0);

      // After release the FSM is in RUN: one edge to DRAIN, one idle edge to SLEEP.
      @(negedge clk);
      rst_n       = 1'b1;
      sleep_req   = 1'b1;
      idle        = 1'b1;
      idle_thresh = 4'd0;
      wake        = 4'h0;
      wake_mask   = 4'h0;
      @(posedge clk);
      #1;
      check("post_reset_drain", 1'b1, 1'b0, 4'h0);
      @(posedge clk);
      #1;
      check("post_reset_sleep", 1'b0, 1'b1, 4'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
